// File: rtl/warp_result_sender_pkg.sv
// Shared constants for the warp result path: FSM encodings and the
// default thread/word geometry used by both the unpack and send sides.
package warp_result_sender_pkg;

  localparam int THREAD_NUMBER_DEF = 256;
  localparam int DATA_WIDTH_DEF    = 16;
  localparam int WORD_WIDTH        = 2 * DATA_WIDTH_DEF;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_WAIT = 4'b0010,
    S_SEND = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

endpackage

// File: rtl/warp_result_sender.sv
// Snapshots all kernel thread results once every thread is valid, then
// streams them pairwise as 32-bit words into the host-bound FIFO.
module warp_result_sender
  import warp_result_sender_pkg::*;
#(
  parameter int THREAD_NUMBER = THREAD_NUMBER_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF
) (
  input  logic                                bus_clk,
  input  logic                                bus_rst_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic [THREAD_NUMBER*DATA_WIDTH-1:0] out_data,
  input  logic [THREAD_NUMBER-1:0]            out_valid,
  input  logic                                fifo_full,
  output logic                                fifo_wr_en,
  output logic [2*DATA_WIDTH-1:0]             fifo_din,
  output logic                                busy,
  output logic                                done
);

  localparam int PAIRS = THREAD_NUMBER / 2;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int IDX_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(PAIRS - 1);
  localparam logic [IDX_W-1:0] K_ONE  = IDX_W'(1);

  state_t state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;

  // Viewed as pairs, entry k is already {thread 2k+1, thread 2k}, so the
  // pair mux is a plain word select.
  logic [PAIRS-1:0][PW-1:0] shadow_q, shadow_d;

  logic all_valid;
  logic wr_en;
  logic last_word;

  assign all_valid = &out_valid;
  assign last_word = (k_q == K_LAST);

  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    shadow_d = shadow_q;
    if (abort) begin
      state_d = S_IDLE;
      k_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) state_d = S_WAIT;
        S_WAIT: begin
          // Only a complete set of valids is ever captured.
          if (all_valid) begin
            state_d  = S_SEND;
            shadow_d = out_data;
            k_d      = '0;
          end
        end
        S_SEND: begin
          if (wr_en) begin
            if (last_word) state_d = S_DONE;
            else           k_d     = k_q + K_ONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: begin
          state_d = S_IDLE;
          k_d     = '0;
        end
      endcase
    end
  end

  always_comb begin
    wr_en    = (state_q == S_SEND) && !fifo_full && !abort;
    fifo_din = '0;
    if (state_q == S_SEND) fifo_din = shadow_q[k_q];
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
  end

  assign fifo_wr_en = wr_en;

endmodule
